serial_add: RTL and testbench



---
 rtl/serial_add.sv | 91 +++++++++
 tb/tb_serial_add.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_add.sv
// rtl/serial_add.sv - bit-serial 8-bit two's-complement adder with start/busy/done handshake
module serial_add (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Y,
    output logic       Cout,
    output logic       Ovf,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] a_sr;
    logic [7:0] b_sr;
    logic [7:0] s_sr;
    logic       c;
    logic [2:0] cnt;

    // The single full-adder cell working on the current LSBs.
    logic s;
    logic c_next;

    always_comb begin
        s      = a_sr[0] ^ b_sr[0] ^ c;
        c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_sr  <= 8'h00;
            b_sr  <= 8'h00;
            s_sr  <= 8'h00;
            c     <= 1'b0;
            cnt   <= 3'd0;
            Y     <= 8'h00;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        c     <= 1'b0;
                        cnt   <= 3'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr <= {1'b0, a_sr[7:1]};
                    b_sr <= {1'b0, b_sr[7:1]};
                    s_sr <= {s, s_sr[7:1]};
                    c    <= c_next;
                    cnt  <= cnt + 3'd1;
                    // Eighth bit: c still holds the carry into bit 7 here.
                    if (cnt == 3'd7) begin
                        Y     <= {s, s_sr[7:1]};
                        Cout  <= c_next;
                        Ovf   <= c ^ c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add.sv
// tb/tb_serial_add.sv - directed-vector bench for serial_add
module tb_serial_add;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Y;
    logic       Cout;
    logic       Ovf;
    logic       busy;
    logic       done;

    int         n_checks;
    int         n_fail;
    logic [7:0] y_hold;

    serial_add dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Y     (Y),
        .Cout  (Cout),
        .Ovf   (Ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A     = 8'hxx;
        B     = 8'hxx;
    endtask

    // Walks the eight RUN cycles, optionally pokes start at RUN cycle poke+1,
    // and stops in the DONE cycle after checking the result.
    task automatic finish_op(input string tag, input logic [7:0] ey, input logic ec,
                             input logic eo, input int poke);
        for (int i = 0; i < 8; i++) begin
            if (i == poke) begin
                start = 1'b1;
                A     = 8'hFF;
                B     = 8'hFF;
            end else begin
                start = 1'b0;
            end
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_nodone"}, done, 1'b0);
            check({tag, "_yheld"}, Y, y_hold);
            tick();
        end
        start = 1'b0;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busylow"}, busy, 1'b0);
        check({tag, "_y"}, Y, ey);
        check({tag, "_cout"}, Cout, ec);
        check({tag, "_ovf"}, Ovf, eo);
        y_hold = ey;
    endtask

    task automatic idle_after(input string tag);
        tick();
        check({tag, "_pulse1"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_yhold"}, Y, y_hold);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        y_hold   = 8'h00;
        reset    = 1'b1;
        start    = 1'b0;
        A        = 8'h00;
        B        = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        check("rst_y", Y, 8'h00);
        check("rst_cout", Cout, 1'b0);
        check("rst_ovf", Ovf, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        launch(8'h3C, 8'h05);
        finish_op("t3c05", 8'h41, 1'b0, 1'b0, -1);
        idle_after("t3c05");

        launch(8'hFF, 8'h01);
        finish_op("tff01", 8'h00, 1'b1, 1'b0, -1);
        idle_after("tff01");
        launch(8'h7F, 8'h01);
        finish_op("t7f01", 8'h80, 1'b0, 1'b1, -1);
        idle_after("t7f01");

        launch(8'h80, 8'h80);
        finish_op("t8080", 8'h00, 1'b1, 1'b1, -1);
        idle_after("t8080");
        launch(8'hC0, 8'hC0);
        finish_op("tc0c0", 8'h80, 1'b1, 1'b0, -1);
        idle_after("tc0c0");

        // Start pulse in RUN cycle 3 must be ignored.
        launch(8'h10, 8'h20);
        finish_op("tign", 8'h30, 1'b0, 1'b0, 2);
        for (int i = 0; i < 4; i++) idle_after("tign");

        // Back-to-back: re-start in the DONE cycle.
        launch(8'h01, 8'h02);
        finish_op("tb2b1", 8'h03, 1'b0, 1'b0, -1);
        launch(8'h0A, 8'h0B);
        finish_op("tb2b2", 8'h15, 1'b0, 1'b0, -1);
        idle_after("tb2b2");

        // Reset during RUN cycle 4.
        launch(8'h55, 8'h55);
        for (int i = 0; i < 3; i++) begin
            check("trst_busy", busy, 1'b1);
            tick();
        end
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        y_hold = 8'h00;
        check("trst_y", Y, 8'h00);
        check("trst_cout", Cout, 1'b0);
        check("trst_ovf", Ovf, 1'b0);
        check("trst_busy0", busy, 1'b0);
        check("trst_done0", done, 1'b0);
        idle_after("trst");
        launch(8'h55, 8'h55);
        finish_op("t5555", 8'hAA, 1'b0, 1'b1, -1);
        idle_after("t5555");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
